// File: rtl/alu_4bit_if.sv
// -----------------------------------------------------------------------------
// alu_4bit_if
// Bundles the ALU operand/opcode inputs and the registered result outputs.
//   En        : operation enable (master -> slave)
//   A, B      : 4-bit unsigned operands (master -> slave)
//   ALU_Sel   : 3-bit opcode (master -> slave)
//   ALU_Out   : registered 4-bit result (slave -> master)
//   Carry_Out : registered carry / borrow / shifted-out bit (slave -> master)
//   Zero      : registered zero flag for ALU_Out (slave -> master)
// The master drives operations; the slave is the ALU itself.
// -----------------------------------------------------------------------------
interface alu_4bit_if;
  logic       En;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] ALU_Sel;
  logic [3:0] ALU_Out;
  logic       Carry_Out;
  logic       Zero;

  modport master (
    output En,
    output A,
    output B,
    output ALU_Sel,
    input  ALU_Out,
    input  Carry_Out,
    input  Zero
  );

  modport slave (
    input  En,
    input  A,
    input  B,
    input  ALU_Sel,
    output ALU_Out,
    output Carry_Out,
    output Zero
  );
endinterface

// File: rtl/alu_4bit.sv
// -----------------------------------------------------------------------------
// alu_4bit
// Registered 4-bit ALU with eight operations (ADD, SUB, AND, OR, XOR, NOT,
// SHL, SHR). Operands sampled on a rising edge with En=1 appear on the
// outputs right after that edge; with En=0 the outputs hold.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset; clears result/carry, sets Zero
//   bus : alu_4bit_if.slave (En, A, B, ALU_Sel in; ALU_Out, Carry_Out, Zero out)
// -----------------------------------------------------------------------------
module alu_4bit (
  input  logic       clk,
  input  logic       rst,
  alu_4bit_if.slave  bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // Zero detect helper so the flag is derived from the very value registered.
  function automatic logic is_zero(input logic [3:0] value);
    return (value == 4'b0000);
  endfunction

  logic [4:0] w_wide;
  logic [3:0] w_result;
  logic       w_carry;
  logic       w_zero;

  logic [3:0] r_alu_out;
  logic       r_carry;
  logic       r_zero;

  // Next-result datapath: one opcode decode producing result and carry.
  always_comb begin
    w_wide   = 5'b00000;
    w_result = 4'b0000;
    w_carry  = 1'b0;
    case (bus.ALU_Sel)
      OP_ADD: begin
        w_wide   = {1'b0, bus.A} + {1'b0, bus.B};
        w_result = w_wide[3:0];
        w_carry  = w_wide[4];
      end
      OP_SUB: begin
        // Bit 4 of the zero-extended difference is the borrow (A < B).
        w_wide   = {1'b0, bus.A} - {1'b0, bus.B};
        w_result = w_wide[3:0];
        w_carry  = w_wide[4];
      end
      OP_AND: begin
        w_result = bus.A & bus.B;
        w_carry  = 1'b0;
      end
      OP_OR: begin
        w_result = bus.A | bus.B;
        w_carry  = 1'b0;
      end
      OP_XOR: begin
        w_result = bus.A ^ bus.B;
        w_carry  = 1'b0;
      end
      OP_NOT: begin
        w_result = ~bus.A;
        w_carry  = 1'b0;
      end
      OP_SHL: begin
        w_result = {bus.A[2:0], 1'b0};
        w_carry  = bus.A[3];
      end
      OP_SHR: begin
        w_result = {1'b0, bus.A[3:1]};
        w_carry  = bus.A[0];
      end
      default: begin
        // Unknown opcode (X/Z in simulation) resolves to a clean zero result.
        w_result = 4'b0000;
        w_carry  = 1'b0;
      end
    endcase
    w_zero = is_zero(w_result);
  end

  // Output registers: reset wins over enable; hold when not enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_out <= 4'b0000;
      r_carry   <= 1'b0;
      r_zero    <= 1'b1;
    end else if (bus.En) begin
      r_alu_out <= w_result;
      r_carry   <= w_carry;
      r_zero    <= w_zero;
    end else begin
      r_alu_out <= r_alu_out;
      r_carry   <= r_carry;
      r_zero    <= r_zero;
    end
  end

  assign bus.ALU_Out   = r_alu_out;
  assign bus.Carry_Out = r_carry;
  assign bus.Zero      = r_zero;

endmodule

// File: tb/tb_alu_4bit.sv
// -----------------------------------------------------------------------------
// tb_alu_4bit
// Directed self-checking bench for alu_4bit. Each step drives inputs, takes
// one rising edge, then compares {ALU_Out, Carry_Out, Zero} against
// hand-computed values shortly after the edge.
// -----------------------------------------------------------------------------
module tb_alu_4bit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  alu_4bit_if bus ();

  alu_4bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare the registered outputs with the expected triple.
  task automatic check(input string tag, input logic [3:0] exp_out,
                       input logic exp_c, input logic exp_z);
    logic [5:0] obs;
    logic [5:0] exp;
    obs = {bus.ALU_Out, bus.Carry_Out, bus.Zero};
    exp = {exp_out, exp_c, exp_z};
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed out=%b c=%b z=%b, expected out=%b c=%b z=%b",
             tag, obs[5:2], obs[1], obs[0], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // Drive one set of inputs, then advance past the next rising edge.
  task automatic step(input logic r, input logic en, input logic [3:0] a,
                      input logic [3:0] b, input logic [2:0] sel);
    rst         = r;
    bus.En      = en;
    bus.A       = a;
    bus.B       = b;
    bus.ALU_Sel = sel;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst         = 1'b1;
    bus.En      = 1'b0;
    bus.A       = 4'b0000;
    bus.B       = 4'b0000;
    bus.ALU_Sel = 3'b000;

    // Reset for two edges, then reset with En=1 still holds reset values
    step(1'b1, 1'b0, 4'b0000, 4'b0000, 3'b000); check("rst_edge1", 4'b0000, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'b0000, 4'b0000, 3'b000); check("rst_edge2", 4'b0000, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'b0101, 4'b0011, 3'b000); check("rst_over_en", 4'b0000, 1'b0, 1'b1);

    // First operation after reset release appears one edge later
    step(1'b0, 1'b1, 4'b0101, 4'b0011, 3'b000); check("add_5_3", 4'b1000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1111, 4'b0001, 3'b000); check("add_wrap", 4'b0000, 1'b1, 1'b1);
    step(1'b0, 1'b1, 4'b1000, 4'b0011, 3'b001); check("sub_8_3", 4'b0101, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b0011, 4'b1000, 3'b001); check("sub_borrow", 4'b1011, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b0111, 4'b0111, 3'b001); check("sub_equal", 4'b0000, 1'b0, 1'b1);

    // Logic ops with A=1100, B=1010
    step(1'b0, 1'b1, 4'b1100, 4'b1010, 3'b010); check("and", 4'b1000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1100, 4'b1010, 3'b011); check("or", 4'b1110, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1100, 4'b1010, 3'b100); check("xor", 4'b0110, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1010, 4'b1111, 3'b101); check("not", 4'b0101, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1111, 4'b0000, 3'b101); check("not_zero", 4'b0000, 1'b0, 1'b1);

    // Shifts
    step(1'b0, 1'b1, 4'b0011, 4'b1111, 3'b110); check("shl_nc", 4'b0110, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1001, 4'b0000, 3'b110); check("shl_c", 4'b0010, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b1000, 4'b1111, 3'b111); check("shr_nc", 4'b0100, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b0001, 4'b0000, 3'b111); check("shr_c", 4'b0000, 1'b1, 1'b1);

    // Enable / hold / latency
    step(1'b0, 1'b1, 4'b0101, 4'b0011, 3'b000); check("en_add", 4'b1000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'b1111, 4'b1111, 3'b001); check("hold1", 4'b1000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 4'b0001, 3'b110); check("hold2", 4'b1000, 1'b0, 1'b0);
    rst         = 1'b0;
    bus.En      = 1'b1;
    bus.A       = 4'b1111;
    bus.B       = 4'b0001;
    bus.ALU_Sel = 3'b000;
    #2;
    check("pre_edge", 4'b1000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("post_edge", 4'b0000, 1'b1, 1'b1);

    // Mid-operation reset discards the sampled operation
    step(1'b0, 1'b1, 4'b1100, 4'b1010, 3'b010); check("pre_mid_rst", 4'b1000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'b1111, 4'b0001, 3'b000); check("mid_rst", 4'b0000, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'b0101, 4'b0011, 3'b000); check("after_rst", 4'b1000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
